// File: rtl/signal_collector.sv
// signal_collector: records {lost, timestamp, data} entries for every change
// (or forced strobe) on a monitored bus into a FIFO. The FIFO is read through a
// first-word-fall-through valid/ready port.
module signal_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         mon_data,
  input  logic                          mon_strobe,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [TS_WIDTH-1:0]           rd_ts,
  output logic                          rd_lost,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + TS_WIDTH + DATA_WIDTH;

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  armed_q, armed_d;
  logic                  lost_pend_q, lost_pend_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic                  full, not_empty, pop, cap, push, drop;
  logic [ENT_W-1:0]      head;

  // Next-state: capture decision, FIFO push/pop/drop bookkeeping, clear override
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = not_empty & rd_ready;
    cap       = enable & (~armed_q | (mon_data != prev_q) | mon_strobe);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push      = cap & (~full | pop);
    drop      = cap & full & ~pop;

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ts_d        = ts_q;
    prev_d      = prev_q;
    armed_d     = armed_q;
    lost_pend_d = lost_pend_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {lost_pend_q, ts_q, mon_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      lost_pend_d     = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (drop) begin
      overflow_d  = 1'b1;
      lost_pend_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
      end
    end
    if (enable) begin
      ts_d    = ts_q + TS_WIDTH'(1);
      prev_d  = mon_data;
      armed_d = 1'b1;
    end

    // clear wins over any push/pop this cycle; stale memory is masked by count
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      ts_d        = '0;
      prev_d      = '0;
      armed_d     = 1'b0;
      lost_pend_d = 1'b0;
      overflow_d  = 1'b0;
      drop_cnt_d  = '0;
    end
  end

  // Entry storage; contents need no reset since reads are gated by rd_valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      prev_q      <= '0;
      armed_q     <= 1'b0;
      lost_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      lost_pend_q <= lost_pend_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Read port: head entry falls through, zeroed while the FIFO is empty
  always_comb begin
    head       = mem_q[rd_ptr_q];
    rd_valid   = (count_q != '0);
    rd_data    = rd_valid ? head[DATA_WIDTH-1:0] : '0;
    rd_ts      = rd_valid ? head[DATA_WIDTH +: TS_WIDTH] : '0;
    rd_lost    = rd_valid ? head[ENT_W-1] : 1'b0;
    fill_level = count_q;
    overflow   = overflow_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule

// File: tb/tb_signal_collector.sv
// Bench for signal_collector: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_signal_collector;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, enable, clear, mon_strobe, rd_ready;
  logic [31:0] mon_data;
  logic        rd_valid, rd_lost, overflow;
  logic [31:0] rd_data, rd_ts;
  logic [4:0]  fill_level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  signal_collector dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .mon_data(mon_data), .mon_strobe(mon_strobe), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ts(rd_ts), .rd_lost(rd_lost),
    .fill_level(fill_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus scalar state
  typedef struct {
    logic        lost;
    logic [31:0] ts;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_ts, m_prev;
  logic        m_armed, m_lost_pend, m_ovf;
  int          m_drops;

  always @(posedge clk) begin
    ent_t e;
    int   n;
    bit   do_pop, do_cap;
    if (rst || clear) begin
      mq.delete();
      m_ts = 0; m_prev = 0; m_armed = 0; m_lost_pend = 0; m_ovf = 0; m_drops = 0;
    end else begin
      n      = mq.size();
      do_pop = (n > 0) && rd_ready;
      do_cap = enable && (!m_armed || mon_data != m_prev || mon_strobe);
      if (do_pop) void'(mq.pop_front());
      if (do_cap) begin
        if (n < DEPTH || do_pop) begin
          e.lost = m_lost_pend; e.ts = m_ts; e.data = mon_data;
          mq.push_back(e);
          m_lost_pend = 0;
        end else begin
          m_ovf = 1; m_lost_pend = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (enable) begin
        m_ts = m_ts + 1; m_prev = mon_data; m_armed = 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("rd_valid", rd_valid, mq.size() > 0);
    check("fill_level", fill_level, mq.size());
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drops);
    if (mq.size() > 0) begin
      check("rd_data", rd_data, mq[0].data);
      check("rd_ts", rd_ts, mq[0].ts);
      check("rd_lost", rd_lost, mq[0].lost);
    end else begin
      check("rd_data_idle", rd_data, 0);
      check("rd_ts_idle", rd_ts, 0);
      check("rd_lost_idle", rd_lost, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] popd [DEPTH];
  logic        popl [DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; enable = 0; clear = 0; mon_strobe = 0; rd_ready = 0; mon_data = 0;
    tick(); tick();
    check("reset_valid", rd_valid, 0);
    check("reset_fill", fill_level, 0);
    rst = 0;

    // 1: first enabled cycle captures initial value, visible next cycle
    enable = 1; mon_data = 32'hAAAAAAAA;
    check("t1_not_same_cycle", rd_valid, 0);
    tick();
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 32'hAAAAAAAA);
    check("t1_ts", rd_ts, 0);
    check("t1_lost", rd_lost, 0);

    // 2: unchanged cycles 1-4, change at ts=5
    repeat (4) tick();
    check("t2_fill_before", fill_level, 1);
    mon_data = 32'h55555555;
    tick();
    check("t2_fill", fill_level, 2);
    enable = 0; rd_ready = 1;
    check("t2_head0", rd_data, 32'hAAAAAAAA);
    tick();
    check("t2_head1_data", rd_data, 32'h55555555);
    check("t2_head1_ts", rd_ts, 5);
    tick();
    check("t2_empty", rd_valid, 0);
    tick();  // empty with rd_ready=1: nothing happens

    // 3: fill, then drop three
    rd_ready = 0; enable = 1;
    for (int i = 0; i < 19; i++) begin
      mon_data = i;
      tick();
    end
    check("t3_fill", fill_level, 16);
    check("t3_ovf", overflow, 1);
    check("t3_drops", drop_cnt, 3);
    enable = 0; rd_ready = 1;
    tick();
    rd_ready = 0; enable = 1; mon_data = 100;
    tick();
    check("t3_refill", fill_level, 16);

    // 4: full, capture with simultaneous pop
    rd_ready = 1; mon_data = 200;
    tick();
    check("t4_drops", drop_cnt, 3);
    check("t4_fill", fill_level, 16);
    enable = 0;
    for (int i = 0; i < DEPTH; i++) begin
      popd[i] = rd_data; popl[i] = rd_lost;
      tick();
    end
    check("t4_first", popd[0], 2);
    check("t4_lost_entry", popd[14], 100);
    check("t4_lost_flag", popl[14], 1);
    check("t4_last", popd[15], 200);
    check("t4_last_lost", popl[15], 0);
    check("t4_prev_lost", popl[13], 0);

    // 5: strobes with constant data, strobe coincident with change
    rd_ready = 0; enable = 1; mon_strobe = 1;
    repeat (3) tick();
    mon_strobe = 0;
    repeat (2) tick();
    check("t5_strobes", fill_level, 3);
    mon_strobe = 1; mon_data = 300;
    tick();
    check("t5_coincident", fill_level, 4);
    mon_strobe = 0; mon_data = 301;
    tick();
    check("t5_fill", fill_level, 5);
    check("t5_ovf_still", overflow, 1);

    // 6: clear flushes everything; re-capture with ts=0
    clear = 1;
    tick();
    check("t6_valid", rd_valid, 0);
    check("t6_fill", fill_level, 0);
    check("t6_ovf", overflow, 0);
    check("t6_drops", drop_cnt, 0);
    clear = 0;
    tick();
    check("t6_recap_data", rd_data, 301);
    check("t6_recap_ts", rd_ts, 0);

    // drop counter saturation
    for (int i = 0; i < 275; i++) begin
      mon_data = 1000 + i;
      tick();
    end
    check("sat_drops", drop_cnt, 255);
    check("sat_fill", fill_level, 16);

    enable = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
